// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 event layout, scan-code prefixes and frame FSM encoding
package ps2_pkg;

  localparam int CODE_W     = 8;
  localparam int EV_W       = CODE_W + 2;
  // bits captured after the start bit: 8 data, parity, stop
  localparam int FRAME_BITS = 10;

  localparam logic [CODE_W-1:0] PFX_EXT = 8'hE0;
  localparam logic [CODE_W-1:0] PFX_REL = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } frame_state_t;

  // event word layout: {release, extended, code}
  function automatic logic [EV_W-1:0] make_event(input logic rel, input logic ext,
                                                 input logic [CODE_W-1:0] code);
    make_event = {rel, ext, code};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line conditioning and frame receiver; odd parity checked when PS2_PARITY_CHECK_EN is defined
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int FILTER_LEN    = 8,
  parameter int TIMEOUT_TICKS = 2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2c,
  input  logic              ps2d,
  output logic [CODE_W-1:0] byte_data,
  output logic              byte_stb,
  output logic              err_stb,
  output logic              timeout_stb
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic                  c_s1, c_s2, d_s1, d_s2;
  logic [CNT_W-1:0]      tick_cnt;
  logic                  tick;
  logic [FILTER_LEN-2:0] filt_hist;
  logic [FILTER_LEN-1:0] filt_win;
  logic                  fclk, fclk_nxt, fall;
  frame_state_t          state, state_nxt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  logic [TO_W-1:0]       to_cnt;
  logic                  timeout, frame_ok, done_tick;

  // two-flop synchronisers on both lines, idle-high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
    end
  end

  // sample tick divider: one-clk tick every CLK_DIV clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick     = (tick_cnt == CNT_W'(CLK_DIV - 1));
  assign filt_win = {filt_hist, c_s2};

  // filtered clock only moves once the whole window of samples agrees
  always_comb begin
    fclk_nxt = fclk;
    if (&filt_win) fclk_nxt = 1'b1;
    else if (~|filt_win) fclk_nxt = 1'b0;
  end

  // sample history and filtered clock advance on ticks only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_hist <= '1;
      fclk      <= 1'b1;
    end else if (tick) begin
      filt_hist <= filt_win[FILTER_LEN-2:0];
      fclk      <= fclk_nxt;
    end
  end

  assign fall      = tick && fclk && !fclk_nxt;
  assign timeout   = (state == ST_RECV) && tick && !fall && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));
  assign done_tick = (state == ST_DONE) && tick;

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = shift_q[FRAME_BITS-1] && (^shift_q[FRAME_BITS-2:0]);
`else
  assign frame_ok = shift_q[FRAME_BITS-1];
`endif

  // frame FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else state <= state_nxt;
  end

  // frame FSM next state: start bit, ten captured bits, one-tick verdict
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fall && !d_s2) state_nxt = ST_RECV;
      ST_RECV: begin
        if (fall && (bit_cnt == BIT_W'(FRAME_BITS - 1))) state_nxt = ST_DONE;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_DONE: if (tick) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // LSB-first shifter, bit counter and inter-edge watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      shift_q <= '0;
      to_cnt  <= '0;
    end else if (state == ST_IDLE) begin
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else if (state == ST_RECV) begin
      if (fall) begin
        shift_q <= {d_s2, shift_q[FRAME_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
        to_cnt  <= '0;
      end else if (tick) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // one-clk verdict strobes and the accepted byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_stb    <= 1'b0;
      err_stb     <= 1'b0;
      timeout_stb <= 1'b0;
      byte_data   <= '0;
    end else begin
      byte_stb    <= done_tick && frame_ok;
      err_stb     <= (done_tick && !frame_ok) || timeout;
      timeout_stb <= timeout;
      if (done_tick) byte_data <= shift_q[CODE_W-1:0];
    end
  end

endmodule

// File: rtl/ps2_event_rx.sv
// rtl/ps2_event_rx.sv - PS/2 receiver top: prefix decoder and show-ahead event FIFO; parity option PS2_PARITY_CHECK_EN
module ps2_event_rx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV       = 25,
  parameter int FILTER_LEN    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int TIMEOUT_TICKS = 2000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2c,
  input  logic                        ps2d,
  output logic [EV_W-1:0]             ev_data,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err,
  input  logic                        clear_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CODE_W-1:0] rx_byte;
  logic              rx_stb, rx_err, rx_timeout;
  logic              rel_flag, ext_flag;
  logic              is_ext, is_rel, push_req, pop, full, do_push, ovf_set;
  logic [EV_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  ps2_frame_rx #(
    .CLK_DIV      (CLK_DIV),
    .FILTER_LEN   (FILTER_LEN),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_frame (
    .clk        (clk),
    .reset      (reset),
    .ps2c       (ps2c),
    .ps2d       (ps2d),
    .byte_data  (rx_byte),
    .byte_stb   (rx_stb),
    .err_stb    (rx_err),
    .timeout_stb(rx_timeout)
  );

  assign is_ext     = (rx_byte == PFX_EXT);
  assign is_rel     = (rx_byte == PFX_REL);
  assign push_req   = rx_stb && !is_ext && !is_rel;
  assign ev_valid   = (count != '0);
  assign full       = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop        = ev_valid && ev_ready;
  assign do_push    = push_req && (!full || pop);
  assign ovf_set    = push_req && full && !pop;
  assign ev_data    = ev_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

  // prefix flags: E0/F0 arm, any other code consumes them, timeout drops them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rel_flag <= 1'b0;
      ext_flag <= 1'b0;
    end else if (rx_timeout) begin
      rel_flag <= 1'b0;
      ext_flag <= 1'b0;
    end else if (rx_stb) begin
      if (is_ext) ext_flag <= 1'b1;
      else if (is_rel) rel_flag <= 1'b1;
      else begin
        rel_flag <= 1'b0;
        ext_flag <= 1'b0;
      end
    end
  end

  // event storage; stale entries are never visible because ev_data is gated by ev_valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= make_event(rel_flag, ext_flag, rx_byte);
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // sticky error flags; a new error in the clearing cycle wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= (overflow && !clear_err) || ovf_set;
      frame_err <= (frame_err && !clear_err) || rx_err;
    end
  end

endmodule

// File: tb/tb_ps2_event_rx.sv
// tb/tb_ps2_event_rx.sv - self-checking bench for ps2_event_rx with a queue-based event model
module tb_ps2_event_rx;

  localparam int CLK_DIV       = 2;
  localparam int FILTER_LEN    = 3;
  localparam int FIFO_DEPTH    = 4;
  localparam int TIMEOUT_TICKS = 60;
  localparam int HALF          = 16;
  localparam int CW            = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ps2c = 1'b1;
  logic          ps2d = 1'b1;
  logic          ev_ready = 1'b0;
  logic          clear_err = 1'b0;
  logic [9:0]    ev_data;
  logic          ev_valid;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  bit m_rel, m_ext, m_ovf, m_ferr;

  always #5 clk = ~clk;

  ps2_event_rx #(
    .CLK_DIV      (CLK_DIV),
    .FILTER_LEN   (FILTER_LEN),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .ev_data   (ev_data),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clear_err (clear_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model of a received frame, written from the protocol rules
  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    bit ok;
    ok = !stop_bad;
`ifdef PS2_PARITY_CHECK_EN
    if (par_bad) ok = 1'b0;
`endif
    if (!ok) begin
      m_ferr = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({m_rel, m_ext, b});
      else m_ovf = 1'b1;
      m_rel = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rel  = 1'b0;
    m_ext  = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // drive one PS/2 frame; cut_at stops before that bit index, optionally pulsing reset there
  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                            input int cut_at, input bit do_reset);
    logic [10:0] fb;
    fb = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2d = fb[i];
      if (i == cut_at) begin
        if (do_reset) begin
          wait_clks(HALF / 2);
          reset = 1'b0;
          wait_clks(3);
          reset = 1'b1;
        end
        ps2c = 1'b1;
        ps2d = 1'b1;
        return;
      end
      wait_clks(HALF);
      ps2c = 1'b0;
      wait_clks(HALF);
      ps2c = 1'b1;
    end
    wait_clks(HALF);
    ps2d = 1'b1;
  endtask

  task automatic rx(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    send_frame(b, par_bad, stop_bad, -1, 1'b0);
    model_frame(b, par_bad, stop_bad);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, fifo_count, exp_q.size());
    check({tag, "_overflow"}, overflow, m_ovf);
    check({tag, "_frame_err"}, frame_err, m_ferr);
  endtask

  task automatic drain(input string tag);
    int guard;
    while (exp_q.size() > 0) begin
      guard = 0;
      while (!ev_valid && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      check({tag, "_valid"}, ev_valid, 1);
      if (!ev_valid) begin
        exp_q.delete();
        break;
      end
      check({tag, "_data"}, ev_data, exp_q.pop_front());
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
    @(negedge clk);
    check({tag, "_empty_count"}, fifo_count, 0);
    check({tag, "_empty_valid"}, ev_valid, 0);
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed no completion expected finish before 900000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int n;
    bit pb;
    model_reset();

    wait_clks(5);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_data", ev_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b1;
    wait_clks(5);

    rx(8'h1C, 1'b0, 1'b0);
    check("1c_count", fifo_count, 1);
    check("1c_data", ev_data, 10'h01C);
    drain("1c");

    rx(8'hE0, 1'b0, 1'b0);
    check("e0_no_event", fifo_count, 0);
    rx(8'hF0, 1'b0, 1'b0);
    check("f0_no_event", fifo_count, 0);
    rx(8'h6B, 1'b0, 1'b0);
    check_state("e0f06b");
    check("e0f06b_data", ev_data, 10'h36B);
    drain("e0f06b");

    rx(8'hF0, 1'b0, 1'b0);
    rx(8'hF0, 1'b0, 1'b0);
    rx(8'hE1, 1'b0, 1'b0);
    check("f0f0e1_data", ev_data, 10'h2E1);
    drain("f0f0e1");

    rx(8'h29, 1'b1, 1'b0);
    check_state("parity");
    drain("parity");
    do_clear();

    rx(8'h33, 1'b0, 1'b1);
    check_state("bad_stop");
    check("bad_stop_err", frame_err, 1);
    do_clear();
    check_state("clear_err");

    rx(8'hE0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 5, 1'b0);
    wait_clks((TIMEOUT_TICKS + 20) * CLK_DIV);
    m_ferr = 1'b1;
    m_rel  = 1'b0;
    m_ext  = 1'b0;
    check_state("timeout");
    rx(8'h15, 1'b0, 1'b0);
    check("after_timeout_data", ev_data, 10'h015);
    drain("after_timeout");
    do_clear();

    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0);
      rx(b, 1'b0, 1'b0);
    end
    check_state("overflow");
    check("overflow_full", fifo_count, FIFO_DEPTH);
    drain("overflow");
    do_clear();
    check_state("overflow_clear");

    for (int i = 0; i < 5; i++) begin
      ps2d = 1'($urandom_range(0, 1));
      ps2c = 1'b0;
      wait_clks(2 * CLK_DIV);
      ps2c = 1'b1;
      wait_clks(20);
    end
    ps2d = 1'b1;
    wait_clks(20);
    check_state("glitch");
    rx(8'hE0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 6, 1'b1);
    model_reset();
    wait_clks(40);
    check_state("mid_reset");
    rx(8'h15, 1'b0, 1'b0);
    check("after_reset_data", ev_data, 10'h015);
    drain("after_reset");

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0: b = 8'hE0;
          1: b = 8'hF0;
          default: b = 8'($urandom_range(0, 255));
        endcase
        pb = ($urandom_range(0, 3) == 0);
        rx(b, pb, 1'b0);
        check("rand_count", fifo_count, exp_q.size());
      end
      check_state("rand");
      drain("rand");
      if (m_ferr) do_clear();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
